// File: rtl/multiplier_4bit_seq_if.sv
// Operand/product handshake bundle for multiplier_4bit_seq.
// master drives operands and product acceptance; slave is the multiplier.
interface multiplier_4bit_seq_if;
    logic       inValid;
    logic [3:0] inA;
    logic [3:0] inB;
    logic       outReady;
    logic [7:0] outProduct;
    logic       outValid;
    logic       inReady;

    modport master (
        output inValid, inA, inB, inReady,
        input  outReady, outProduct, outValid
    );

    modport slave (
        input  inValid, inA, inB, inReady,
        output outReady, outProduct, outValid
    );
endinterface

// File: rtl/multiplier_4bit_seq.sv
// 4x4 unsigned shift-add multiplier, IDLE/RUN/DONE handshake FSM.
// Optional MULT_ZERO_SKIP_EN: zero operand goes straight to DONE.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       inCarry,
    output logic [3:0] sum,
    output logic       outCarry
);
    assign {outCarry, sum} = {1'b0, a} + {1'b0, b} + {4'b0, inCarry};
endmodule

module multiplier_4bit_seq (
    input logic                 clk,
    input logic                 reset,
    multiplier_4bit_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic [7:0] acc;
    logic [1:0] count;
    logic [7:0] product;
    logic       valid;
    logic       ready;

    logic [3:0]  sum;
    logic        carry;
    logic [4:0]  partial;
    logic [11:0] shifted;

    adder_4bit u_add (
        .a        (acc[7:4]),
        .b        (mcand),
        .inCarry  (1'b0),
        .sum      (sum),
        .outCarry (carry)
    );

    // Partial sum (carry kept as fifth bit), then the
    // {carry, acc, multiplier} chain shifted right by one.
    always_comb begin
        partial = mplier[0] ? {carry, sum} : {1'b0, acc[7:4]};
        shifted = {partial, acc[3:0], mplier[3:1]};
    end

    // Handshake FSM with registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= 4'd0;
            mplier  <= 4'd0;
            acc     <= 8'd0;
            count   <= 2'd0;
            product <= 8'd0;
            valid   <= 1'b0;
            ready   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.inValid) begin
                        mcand  <= bus.inA;
                        mplier <= bus.inB;
                        acc    <= 8'd0;
                        count  <= 2'd0;
                        ready  <= 1'b0;
`ifdef MULT_ZERO_SKIP_EN
                        if (bus.inA == 4'd0 || bus.inB == 4'd0) begin
                            state   <= DONE;
                            product <= 8'd0;
                            valid   <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc    <= shifted[11:4];
                    mplier <= shifted[3:0];
                    count  <= count + 2'd1;
                    if (count == 2'd3) begin
                        state   <= DONE;
                        product <= shifted[11:4];
                        valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.inReady) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.outProduct = product;
    assign bus.outValid   = valid;
    assign bus.outReady   = ready;
endmodule

// File: tb/tb_multiplier_4bit_seq.sv
// Self-checking bench for multiplier_4bit_seq.
// Scoreboard queue of expected products, one task per scenario.
module tb_multiplier_4bit_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    multiplier_4bit_seq_if bus ();

    multiplier_4bit_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Edges from acceptance (counted as 1) to the first outValid sample.
    function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 4'd0 || b == 4'd0) return 1;
`endif
        return 5;
    endfunction

    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] e, input string name);
        int n;
        logic [7:0] want;
        n = 0;
        while (!bus.outReady && n < 20) begin
            tick;
            n++;
        end
        bus.inA = a;
        bus.inB = b;
        bus.inValid = 1'b1;
        exp_q.push_back(e);
        tick;
        bus.inValid = 1'b0;
        n = 1;
        while (!bus.outValid && n < 20) begin
            tick;
            n++;
        end
        want = exp_q.pop_front();
        checks++;
        if (n !== exp_lat(a, b)) begin
            failures++;
            $display("FAIL %s_latency a=%0d b=%0d got=%0d want=%0d",
                     name, a, b, n, exp_lat(a, b));
        end
        checks++;
        if (bus.outProduct !== want) begin
            failures++;
            $display("FAIL %s_product a=%0d b=%0d got=%h want=%h",
                     name, a, b, bus.outProduct, want);
        end
        bus.inReady = 1'b1;
        tick;
        bus.inReady = 1'b0;
        checks++;
        if (bus.outValid !== 1'b0 || bus.outReady !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle valid=%b ready=%b want valid=0 ready=1",
                     name, bus.outValid, bus.outReady);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.inValid = 1'b1;
        bus.inReady = 1'b1;
        bus.inA = 4'd3;
        bus.inB = 4'd3;
        tick;
        tick;
        reset = 1'b0;
        bus.inValid = 1'b0;
        bus.inReady = 1'b0;
        checks++;
        if (bus.outReady !== 1'b1 || bus.outValid !== 1'b0 ||
            bus.outProduct !== 8'h00) begin
            failures++;
            $display("FAIL reset ready=%b valid=%b prod=%h want 1 0 00",
                     bus.outReady, bus.outValid, bus.outProduct);
        end
    endtask

    task automatic test_basic;
        do_op(4'd3, 4'd5, 8'h0F, "basic");
        do_op(4'd15, 4'd15, 8'hE1, "max");
    endtask

    task automatic test_exhaustive;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_op(4'(a), 4'(b), 8'(a * b), "all");
    endtask

    task automatic test_zero;
        do_op(4'd0, 4'd9, 8'h00, "zero_a");
        do_op(4'd9, 4'd0, 8'h00, "zero_b");
    endtask

    task automatic test_stall;
        int n;
        logic [7:0] want;
        bus.inA = 4'd7;
        bus.inB = 4'd9;
        bus.inValid = 1'b1;
        exp_q.push_back(8'h3F);
        tick;
        bus.inValid = 1'b0;
        n = 0;
        while (!bus.outValid && n < 20) begin
            tick;
            n++;
        end
        want = exp_q.pop_front();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.outValid !== 1'b1 || bus.outProduct !== want) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d valid=%b prod=%h want 1 %h",
                         i, bus.outValid, bus.outProduct, want);
            end
            bus.inValid = i[0];
            bus.inA = 4'd1;
            bus.inB = 4'd1;
            tick;
        end
        bus.inValid = 1'b0;
        bus.inReady = 1'b1;
        tick;
        bus.inReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.outValid !== 1'b0 || bus.outReady !== 1'b1) begin
                failures++;
                $display("FAIL stall_after valid=%b ready=%b want 0 1",
                         bus.outValid, bus.outReady);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        bus.inA = 4'd6;
        bus.inB = 4'd6;
        bus.inValid = 1'b1;
        tick;
        bus.inValid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (bus.outValid !== 1'b0 || bus.outProduct !== 8'h00 ||
            bus.outReady !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset valid=%b prod=%h ready=%b want 0 00 1",
                     bus.outValid, bus.outProduct, bus.outReady);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.outValid) seen++;
            tick;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_pulse got=%0d want=0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int acc_e[2];
        int done_e[2];
        int na;
        int seen;
        logic [7:0] want;
        na = 0;
        seen = 0;
        bus.inA = 4'd2;
        bus.inB = 4'd3;
        bus.inValid = 1'b1;
        bus.inReady = 1'b1;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            if (bus.outReady && na < 2) begin
                acc_e[na] = cyc + 1;
                exp_q.push_back(na == 0 ? 8'd6 : 8'd20);
                na++;
            end
            if (bus.outValid) begin
                want = exp_q.pop_front();
                checks++;
                if (bus.outProduct !== want) begin
                    failures++;
                    $display("FAIL b2b_product got=%h want=%h",
                             bus.outProduct, want);
                end
                done_e[seen] = cyc + 1;
                seen++;
            end
            tick;
            if (na == 1) begin
                bus.inA = 4'd4;
                bus.inB = 4'd5;
            end
        end
        bus.inValid = 1'b0;
        bus.inReady = 1'b0;
        checks++;
        if (seen != 2 || na != 2) begin
            failures++;
            $display("FAIL b2b_count ops=%0d accepts=%0d want 2 2", seen, na);
        end else begin
            checks++;
            if (acc_e[1] != done_e[0] + 1) begin
                failures++;
                $display("FAIL b2b_gap accept=%0d want=%0d",
                         acc_e[1], done_e[0] + 1);
            end
        end
        tick;
    endtask

    initial begin
        bus.inValid = 1'b0;
        bus.inReady = 1'b0;
        bus.inA = 4'd0;
        bus.inB = 4'd0;
        test_reset;
        test_basic;
        test_stall;
        test_reset_mid_run;
        test_zero;
        test_back_to_back;
        test_exhaustive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multiplier_4bit_seq.md
MULTIPLIER_4BIT_SEQ -- requirements
Module: multiplier_4bit_seq

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 inValid  input  1  operand pair valid.
REQ-005 inA  input  4  multiplicand, unsigned.
REQ-006 inB  input  4  multiplier, unsigned.
REQ-007 outReady  output  1  block accepts operands this cycle.
REQ-008 outProduct  output  8  unsigned product inA*inB.
REQ-009 outValid  output  1  outProduct valid.
REQ-010 inReady  input  1  downstream accepts the product.

Function
REQ-011 The block SHALL be a shift-add multiplier whose partial-sum add is one adder_4bit instance: upper accumulator nibble plus multiplicand, inCarry tied 0, outCarry kept as the fifth sum bit.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: outReady=1, outValid=0; on inValid=1 the block SHALL latch inA/inB, clear the 8-bit accumulator and the 2-bit step counter, and go to RUN.
REQ-014 RUN: outReady=0, outValid=0; each cycle, if the current multiplier LSB is 1, the upper accumulator nibble SHALL take the adder sum; the {carry, acc, multiplier} chain SHALL then shift right 1 bit, and the counter SHALL increment.
REQ-015 After the 4th RUN cycle (counter wrap 3->0) the FSM SHALL go to DONE.
REQ-016 Latency: outValid SHALL be high in the 5th cycle after the acceptance edge, i.e. acceptance edge + 4 RUN edges.
REQ-017 DONE: outValid=1, outReady=0; outProduct SHALL hold stable until inReady=1, then the FSM SHALL go to IDLE on that edge.
REQ-018 No back-to-back acceptance: a new operand SHALL NOT be accepted in the DONE->IDLE handoff cycle; earliest acceptance is the following IDLE cycle.
REQ-019 inValid, inA and inB SHALL be ignored outside IDLE.
REQ-020 outProduct SHALL be registered, with no combinational path from any input.
REQ-021 Maximum result: 15*15=225 (0xE1); no overflow is possible.

Reset
REQ-022 On reset=1 at a clock edge the FSM SHALL go to IDLE and clear outProduct, the accumulator, the counter and the latched operands to 0, from any state.
REQ-023 After reset, outValid=0 and outReady=1.
REQ-024 Reset mid-RUN or mid-DONE SHALL discard the operation with no outValid pulse.
REQ-025 Reset SHALL take priority over inValid and inReady in the same cycle.

Configuration
REQ-026 Macro MULT_ZERO_SKIP_EN: when defined, an accepted pair with inA==0 or inB==0 SHALL go IDLE->DONE directly, with outProduct=0 and outValid high in the cycle after acceptance.
REQ-027 Without MULT_ZERO_SKIP_EN, every operation SHALL take the full 4 RUN cycles, zero operands included.

Verification
REQ-028 Reset, then inA=3, inB=5, inValid pulse, inReady=1 -> outValid high exactly 4 cycles after acceptance with outProduct=0x0F, then IDLE and outReady=1.
REQ-029 inA=15, inB=15 -> outProduct=0xE1; all 256 operand pairs -> outProduct matches a reference multiply.
REQ-030 inA=7, inB=9, inReady held 0 for 6 cycles -> outValid and outProduct=0x3F stable throughout; inValid pulses during the stall are ignored.
REQ-031 reset asserted in the 2nd RUN cycle of inA=6, inB=6 -> no outValid, outProduct=0x00, outReady=1 on the next cycle.
REQ-032 inA=0, inB=9: with MULT_ZERO_SKIP_EN -> outValid 1 cycle after acceptance, product 0x00; without it -> 4 cycles, product 0x00.
REQ-033 inValid held 1 with inReady=1 across two operations -> second acceptance no earlier than the cycle after the DONE->IDLE edge.
